// File: rtl/teclado_pkg.sv
// Shared types and the column priority encoder for the hex keypad controller.
// Purely combinational helpers, no timing or flow-control of their own.
package teclado_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEB_PRESS,
        CAPTURE,
        WAIT_REL,
        DEB_REL
    } estado_t;

    typedef logic [3:0] tecla_t;
    typedef logic [1:0] fila_t;

    // Lowest set bit wins so a multi-column press resolves deterministically.
    function automatic logic [1:0] codificar_columna(input logic [3:0] mask);
        logic [1:0] col;
        col = 2'd0;
        if (mask[0])      col = 2'd0;
        else if (mask[1]) col = 2'd1;
        else if (mask[2]) col = 2'd2;
        else if (mask[3]) col = 2'd3;
        return col;
    endfunction

endpackage

// File: rtl/fifo_teclas.sv
// Key buffer: first-word fall-through FIFO, head/flags valid the cycle after push/pop.
// A push into a full buffer is refused unless a pop happens in the same cycle; pop on empty is ignored.
module fifo_teclas
    import teclado_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          push,
    input  logic                          pop,
    input  tecla_t                        dato_wr,
    output tecla_t                        dato_rd,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    tecla_t        mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dato_rd = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= dato_wr;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/controlador_teclado.sv
// Keypad row scanner with press/release debounce FSM feeding a key FIFO; columns reach the FSM 2 cycles late.
// Consumer pops via leer_i when data_available_o=1; keys captured while the FIFO is full are dropped and flagged.
module controlador_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [3:0]                    columnas_i,
    input  logic                          leer_i,
    output fila_t                         fila_o,
    output logic                          data_available_o,
    output tecla_t                        dato_o,
    output logic [$clog2(FIFO_DEPTH):0]   ocupacion_o,
    output logic                          overflow_o,
    output logic                          ocupado_o
);

    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1;
    logic [3:0]    mask;
    estado_t       estado, estado_nxt;
    fila_t         fila, fila_nxt;
    logic [SW-1:0] dwell, dwell_nxt;
    logic [DW-1:0] deb, deb_nxt;
    logic [3:0]    latched, latched_nxt;
    logic          push;
    logic          full;
    logic          empty;
    logic          overflow;

    always_comb begin
        estado_nxt  = estado;
        fila_nxt    = fila;
        dwell_nxt   = dwell;
        deb_nxt     = deb;
        latched_nxt = latched;
        push        = 1'b0;
        case (estado)
            SCAN: begin
                if (mask != 4'd0) begin
                    estado_nxt  = DEB_PRESS;
                    latched_nxt = mask;
                    dwell_nxt   = '0;
                    deb_nxt     = '0;
                end else if (dwell == SCAN_LAST) begin
                    dwell_nxt = '0;
                    fila_nxt  = fila + 2'd1;
                end else begin
                    dwell_nxt = dwell + SW'(1);
                end
            end
            DEB_PRESS: begin
                if (mask != latched) begin
                    estado_nxt = SCAN;
                    dwell_nxt  = '0;
                    deb_nxt    = '0;
                end else if (deb == DEB_LAST) begin
                    estado_nxt = CAPTURE;
                    deb_nxt    = '0;
                end else begin
                    deb_nxt = deb + DW'(1);
                end
            end
            CAPTURE: begin
                push       = 1'b1;
                estado_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (mask == 4'd0) begin
                    estado_nxt = DEB_REL;
                    deb_nxt    = '0;
                end
            end
            DEB_REL: begin
                if (mask != 4'd0) begin
                    estado_nxt = WAIT_REL;
                end else if (deb == DEB_LAST) begin
                    estado_nxt = SCAN;
                    fila_nxt   = fila + 2'd1;
                    dwell_nxt  = '0;
                    deb_nxt    = '0;
                end else begin
                    deb_nxt = deb + DW'(1);
                end
            end
            default: begin
                estado_nxt = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1    <= '0;
            mask     <= '0;
            estado   <= SCAN;
            fila     <= '0;
            dwell    <= '0;
            deb      <= '0;
            latched  <= '0;
            overflow <= 1'b0;
        end else begin
            sync1    <= columnas_i;
            mask     <= sync1;
            estado   <= estado_nxt;
            fila     <= fila_nxt;
            dwell    <= dwell_nxt;
            deb      <= deb_nxt;
            latched  <= latched_nxt;
            // Full implies non-empty, so leer_i alone means a pop frees the slot this cycle.
            if (push && full && !leer_i) begin
                overflow <= 1'b1;
            end
        end
    end

    fifo_teclas #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (push),
        .pop     (leer_i),
        .dato_wr ({fila, codificar_columna(latched)}),
        .dato_rd (dato_o),
        .full    (full),
        .empty   (empty),
        .count   (ocupacion_o)
    );

    assign fila_o           = fila;
    assign data_available_o = !empty;
    assign overflow_o       = overflow;
    assign ocupado_o        = (estado != SCAN);

endmodule

// File: tb/tb_controlador_teclado.sv
// Directed bench for controlador_teclado with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, FIFO_DEPTH=4.
module tb_controlador_teclado;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [3:0] columnas_i;
    logic       leer_i;
    logic [1:0] fila_o;
    logic       data_available_o;
    logic [3:0] dato_o;
    logic [2:0] ocupacion_o;
    logic       overflow_o;
    logic       ocupado_o;

    int checks = 0;
    int errors = 0;

    controlador_teclado #(
        .SCAN_CYCLES(4),
        .DEBOUNCE_CYCLES(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .columnas_i       (columnas_i),
        .leer_i           (leer_i),
        .fila_o           (fila_o),
        .data_available_o (data_available_o),
        .dato_o           (dato_o),
        .ocupacion_o      (ocupacion_o),
        .overflow_o       (overflow_o),
        .ocupado_o        (ocupado_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns right as the scanner enters row v, so the row dwell counter is 0.
    task automatic wait_fila(input logic [1:0] v);
        int n;
        n = 0;
        while (fila_o == v && n < 64) begin tick(); n++; end
        while (fila_o != v && n < 64) begin tick(); n++; end
        checks++;
        assert (n < 64) else begin
            errors++;
            $error("FAIL wait_fila: row %0d not reached within 64 cycles", v);
        end
    endtask

    // Press lands in DEB_PRESS after 3 edges, CAPTURE state after 11, push on edge 12.
    task automatic press(input logic [1:0] row, input logic [3:0] col, input logic pop_cap);
        wait_fila(row);
        columnas_i = col;
        repeat (11) tick();
        leer_i = pop_cap;
        tick();
        leer_i = 1'b0;
        repeat (8) tick();
        columnas_i = 4'd0;
        repeat (12) tick();
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] exp);
        check(tag, dato_o, exp);
        leer_i = 1'b1;
        tick();
        leer_i = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fila"}, fila_o, 0);
        check({tag, "_avail"}, data_available_o, 0);
        check({tag, "_dato"}, dato_o, 0);
        check({tag, "_ocup"}, ocupacion_o, 0);
        check({tag, "_ovf"}, overflow_o, 0);
        check({tag, "_busy"}, ocupado_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i    = 1'b0;
        columnas_i = 4'd0;
        leer_i     = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // 1. Scan wrap, sampled mid-row
        tick(); tick();
        check("scan_r0", fila_o, 0);
        repeat (4) tick();
        check("scan_r1", fila_o, 1);
        repeat (4) tick();
        check("scan_r2", fila_o, 2);
        repeat (4) tick();
        check("scan_r3", fila_o, 3);
        check("scan_busy", ocupado_o, 0);
        repeat (4) tick();
        check("scan_wrap", fila_o, 0);
        check("scan_avail", data_available_o, 0);

        // 2. Clean press on row 2, column 2
        wait_fila(2);
        columnas_i = 4'b0100;
        repeat (30) tick();
        check("press_dato", dato_o, 4'b1010);
        check("press_ocup", ocupacion_o, 1);
        check("press_avail", data_available_o, 1);
        check("press_busy", ocupado_o, 1);
        check("press_frozen", fila_o, 2);
        columnas_i = 4'd0;
        repeat (12) tick();
        check("release_fila", fila_o, 3);
        check("release_busy", ocupado_o, 0);
        check("release_ocup", ocupacion_o, 1);
        leer_i = 1'b1;
        tick();
        check("pop_avail", data_available_o, 0);
        check("pop_ocup", ocupacion_o, 0);
        tick();
        leer_i = 1'b0;
        check("pop_empty_ocup", ocupacion_o, 0);

        // 3. Bounce shorter than the debounce window
        wait_fila(1);
        columnas_i = 4'b0001;
        repeat (5) tick();
        check("bounce_busy", ocupado_o, 1);
        columnas_i = 4'd0;
        repeat (5) tick();
        check("bounce_idle", ocupado_o, 0);
        check("bounce_fila", fila_o, 1);
        check("bounce_ocup", ocupacion_o, 0);

        // 4. Multi-column press: column 1 beats column 3
        press(2'd1, 4'b1010, 1'b0);
        check("multi_dato", dato_o, 4'b0101);
        check("multi_ocup", ocupacion_o, 1);
        pop_expect("multi_pop", 4'b0101);

        // 5. Overflow: fifth key dropped, sticky flag survives draining
        press(2'd0, 4'b0001, 1'b0);
        press(2'd1, 4'b0010, 1'b0);
        press(2'd2, 4'b1000, 1'b0);
        press(2'd3, 4'b0100, 1'b0);
        check("fill_ocup", ocupacion_o, 4);
        check("fill_ovf", overflow_o, 0);
        press(2'd0, 4'b0010, 1'b0);
        check("ovf_ocup", ocupacion_o, 4);
        check("ovf_flag", overflow_o, 1);
        check("ovf_head", dato_o, 4'b0000);
        pop_expect("ovf_pop0", 4'b0000);
        pop_expect("ovf_pop1", 4'b0101);
        pop_expect("ovf_pop2", 4'b1011);
        pop_expect("ovf_pop3", 4'b1110);
        check("ovf_drained", data_available_o, 0);
        check("ovf_sticky", overflow_o, 1);

        // 6. Full FIFO with a pop during the capture cycle
        reset_i = 1'b1;
        #1;
        check_reset_values("rst2");
        tick();
        reset_i = 1'b0;
        press(2'd0, 4'b0001, 1'b0);
        press(2'd1, 4'b0001, 1'b0);
        press(2'd2, 4'b0001, 1'b0);
        press(2'd3, 4'b0001, 1'b0);
        check("full_ocup", ocupacion_o, 4);
        press(2'd0, 4'b0100, 1'b1);
        check("simul_ocup", ocupacion_o, 4);
        check("simul_ovf", overflow_o, 0);
        pop_expect("simul_pop0", 4'b0100);
        pop_expect("simul_pop1", 4'b1000);
        pop_expect("simul_pop2", 4'b1100);
        check("simul_tail", dato_o, 4'b0010);

        // Reset in the middle of a press debounce with one key still queued
        wait_fila(2);
        columnas_i = 4'b0001;
        repeat (5) tick();
        check("mid_busy", ocupado_o, 1);
        reset_i = 1'b1;
        #1;
        check_reset_values("rst_mid");
        columnas_i = 4'd0;
        tick();
        reset_i = 1'b0;
        repeat (20) tick();
        check("post_rst_ocup", ocupacion_o, 0);
        check("post_rst_busy", ocupado_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
